// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the data-memory arbiter.
//   state_e : access sequencer states (IDLE -> ISSUE -> RESP)
//   port_t  : requester id (PORT0 = pipeline MEM stage, PORT1 = DMA/debug)
//   cmd_t   : command latched at arbitration {we, addr, wdata, port, oor}
package dmem_arb_pkg;

  localparam int unsigned CMD_ADDR_W = 16;
  localparam int unsigned CMD_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef logic port_t;
  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

  typedef struct packed {
    logic                  we;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    port_t                 port;
    logic                  oor;
  } cmd_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: two-way winner selection with a tie-break pointer.
//   clock, reset : clock / synchronous active-high reset
//   i_req0/1     : requests from port 0 / port 1
//   i_update     : a grant is being taken this cycle (advances the pointer)
//   o_win        : winning port (only meaningful when a request is present)
// Build option DMEM_ARB_RR_EN: round-robin tie-break. Without it the pointer
// stays on port 0, giving fixed priority to port 0.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  i_req0,
  input  logic  i_req1,
  input  logic  i_update,
  output port_t o_win
);

  port_t r_ptr;
  port_t w_ptr_next;

  always_comb begin
    if (i_req0 && i_req1) o_win = r_ptr;
    else if (i_req1)      o_win = PORT1;
    else                  o_win = PORT0;
  end

`ifdef DMEM_ARB_RR_EN
  // The port just granted loses the next tie.
  assign w_ptr_next = (o_win == PORT0) ? PORT1 : PORT0;
`else
  assign w_ptr_next = PORT0;
`endif

  always_ff @(posedge clock) begin
    if (reset)         r_ptr <= PORT0;
    else if (i_update) r_ptr <= w_ptr_next;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between requester 0
// (pipeline MEM stage) and requester 1 (DMA/debug loader).
// Every access runs IDLE -> ISSUE -> RESP (3 cycles).
//   clock, reset          : clock / synchronous active-high reset
//   pN_req/we/addr/wdata  : request from port N (held until pN_gnt)
//   pN_gnt                : one-cycle accept pulse (ISSUE)
//   pN_rvalid, pN_rdata   : read data pulse (RESP) / captured read data
//   pN_err                : out-of-range access pulse (RESP)
//   mem_address/read/write/wdata, mem_rdata : data_memory port
//   busy                  : sequencer not IDLE
// Build option DMEM_ARB_RR_EN selects round-robin tie-break (default: fixed
// priority to port 0).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MEM_SIZE = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            r_state;
  state_e            w_state_next;
  cmd_t              r_cmd;
  cmd_t              w_cmd_sel;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  port_t             w_win;
  logic              w_accept;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_capture;

  dmem_arb_pick u_pick (
    .clock    (clock),
    .reset    (reset),
    .i_req0   (p0_req),
    .i_req1   (p1_req),
    .i_update (w_accept),
    .o_win    (w_win)
  );

  assign w_sel_addr = (w_win == PORT1) ? p1_addr : p0_addr;

  always_comb begin
    w_cmd_sel       = '0;
    w_cmd_sel.we    = (w_win == PORT1) ? p1_we : p0_we;
    w_cmd_sel.addr  = CMD_ADDR_W'(w_sel_addr);
    w_cmd_sel.wdata = CMD_DATA_W'((w_win == PORT1) ? p1_wdata : p0_wdata);
    w_cmd_sel.port  = w_win;
    w_cmd_sel.oor   = (w_sel_addr >= ADDR_W'(MEM_SIZE));
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    p0_gnt       = 1'b0;
    p1_gnt       = 1'b0;
    p0_rvalid    = 1'b0;
    p1_rvalid    = 1'b0;
    p0_err       = 1'b0;
    p1_err       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (p0_req || p1_req) begin
          w_state_next = ST_ISSUE;
          w_accept     = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_RESP;
        p0_gnt       = (r_cmd.port == PORT0);
        p1_gnt       = (r_cmd.port == PORT1);
        mem_read     = !r_cmd.oor && !r_cmd.we;
        mem_write    = !r_cmd.oor &&  r_cmd.we;
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
        p0_rvalid    = (r_cmd.port == PORT0) && !r_cmd.we && !r_cmd.oor;
        p1_rvalid    = (r_cmd.port == PORT1) && !r_cmd.we && !r_cmd.oor;
        p0_err       = (r_cmd.port == PORT0) && r_cmd.oor;
        p1_err       = (r_cmd.port == PORT1) && r_cmd.oor;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Read data is sampled on the ISSUE->RESP edge, only for in-range reads,
  // so an error response leaves the previous rdata in place.
  assign w_capture = (r_state == ST_ISSUE) && !r_cmd.we && !r_cmd.oor;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cmd    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_cmd <= w_cmd_sel;
      if (w_capture && (r_cmd.port == PORT0)) r_rdata0 <= mem_rdata;
      if (w_capture && (r_cmd.port == PORT1)) r_rdata1 <= mem_rdata;
    end
  end

  assign mem_address = ADDR_W'(r_cmd.addr);
  assign mem_wdata   = DATA_W'(r_cmd.wdata);
  assign p0_rdata    = r_rdata0;
  assign p1_rdata    = r_rdata1;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the 16-bit data memory. Shares the single memory port between requester 0 (pipeline MEM stage) and requester 1 (DMA/debug loader), drives the memory's address/read/write/data strobes from registered state, and returns captured read data with a one-cycle valid pulse. Sits between the pipeline/DMA and `data_memory`, replacing their direct connection.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `MEM_SIZE`, 512, number of valid words; addresses ≥ MEM_SIZE are out of range

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `pN_req`  in  1  request, N∈{0,1}; held until `pN_gnt`
- `pN_we`  in  1  1 = write, 0 = read; stable while `pN_req`
- `pN_addr`  in  ADDR_W  word address
- `pN_wdata`  in  DATA_W  write data
- `pN_gnt`  out  1  one-cycle pulse: request accepted
- `pN_rvalid`  out  1  one-cycle pulse: `pN_rdata` valid (reads only)
- `pN_rdata`  out  DATA_W  captured read data, holds until next rvalid
- `pN_err`  out  1  one-cycle pulse: out-of-range access rejected
- `mem_address`  out  ADDR_W  to memory `address`
- `mem_read`  out  1  to memory `read`
- `mem_write`  out  1  to memory `write`
- `mem_wdata`  out  DATA_W  to memory `data_bus_write`
- `mem_rdata`  in  DATA_W  from memory `data_bus_read`
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM: IDLE → ISSUE → RESP → IDLE. Every access occupies exactly 3 cycles; max throughput one access per 3 cycles.
- IDLE: if any req, pick winner, latch its we/addr/wdata and port id into command regs, go ISSUE. No req: stay IDLE.
- ISSUE: `mem_address`/`mem_wdata` = latched values; exactly one of `mem_read`/`mem_write` high, never both; `pN_gnt` high for winner.
- RESP: strobes low; for reads, `mem_rdata` (sampled at the ISSUE→RESP edge) is in `pN_rdata`, `pN_rvalid` high.
- Out-of-range (addr ≥ MEM_SIZE): still takes the IDLE→ISSUE→RESP path, but ISSUE asserts gnt only, no strobes; RESP pulses `pN_err`, no rvalid, `pN_rdata` unchanged.
- Requester must drop req in the cycle after gnt, else it is re-arbitrated as a new access.
- Both strobes low whenever not in ISSUE (memory drives Z).

## Timing
- Reset values: state IDLE, all gnt/rvalid/err/strobes 0, `mem_address`/`mem_wdata`/`pN_rdata` 0, `busy` 0, RR pointer favours port 0.
- Req sampled at edge T (IDLE) → gnt and strobe during cycle T+1 → rvalid/err during T+2 → IDLE at T+3, next arbitration at edge T+3.
- Read latency req→rvalid: 2 cycles. Writes: memory updated during T+1.
- Simultaneous req: winner per arbitration mode; loser waits, no gnt.
- New req arriving while busy: ignored until IDLE; no queueing.
- Reset in ISSUE: strobes still high that cycle (sync reset), so an issued write completes; state returns IDLE, no rvalid/err.
- Reset in RESP: rvalid/err suppressed from next edge on.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin; after a grant to port k, port 1−k wins the next tie. Pointer updates only on grant.
- Not defined: fixed priority, port 0 always wins ties; port 1 may starve.

## Structure
- Package `dmem_arb_pkg`: FSM state enum (IDLE, ISSUE, RESP), port-id type, command struct {we, addr, wdata, port, oor}.
- Sub-module `dmem_arb_pick`: 2-way pick logic with pointer, RR behaviour under `DMEM_ARB_RR_EN`.

## Test plan
- p0 write 0x00A5 to addr 3, then p0 read addr 3 → `mem_write` one cycle at T+1, later `p0_rvalid` with `p0_rdata`=0x00A5 two cycles after read req.
- p0 and p1 both reading addr 2 and 4 continuously with RR → grants alternate p0,p1,p0,p1; each gnt 3 cycles apart.
- Same as above without macro → only p0 granted while p0_req held; p1 granted after p0 drops.
- p1 read addr 512 → `p1_gnt` at T+1, `mem_read`/`mem_write` stay 0, `p1_err` at T+2, no rvalid.
- Reset asserted in RESP of a read → no `rvalid` next cycle, `busy`=0, all outputs at reset values.
- Write to addr 7 with reset high in its ISSUE cycle → mem[7] updated, no gnt-related rvalid, FSM IDLE after reset.
